// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction tree with multi-beat accumulation, bias, optional ReLU and a valid/ready output.
// Define ADDER_TREE_SATURATE_EN to clamp results to W bits; otherwise the low W bits are kept (wrap-around).
module pipelined_adder_tree #(
    parameter int W         = 16,
    parameter int L         = 128,
    parameter int ACC_GUARD = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    input  logic [W*L-1:0] A_in,
    input  logic [W-1:0]   Bias,
    input  logic           en_relu,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   C
);
    localparam int LOG2L = $clog2(L);
    localparam int TW    = W + LOG2L;
    localparam int AW    = W + LOG2L + ACC_GUARD;
    localparam int RW    = AW + 1;

    typedef struct packed {
        logic         valid;
        logic         last;
        logic [W-1:0] bias;
        logic         relu;
    } side_t;

    logic stall;
    logic out_valid_d, out_valid_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Level k holds L>>k partial sums, each one bit wider than the level below it.
    for (genvar k = 0; k <= LOG2L; k++) begin : lvl
        localparam int N  = L >> k;
        localparam int LW = W + k;
        logic signed [LW-1:0] node [N];
        side_t                side;

        if (k == 0) begin : g_in
            for (genvar j = 0; j < N; j++) begin : g_op
                assign node[j] = A_in[j*W +: W];
            end
            assign side = '{valid: in_valid && !stall, last: in_last, bias: Bias, relu: en_relu};
        end else begin : g_add
            logic signed [LW-1:0] node_d [N];
            logic signed [LW-1:0] node_q [N];
            side_t                side_d, side_q;

            always_comb begin
                side_d = side_q;
                node_d = node_q;
                if (!stall) begin
                    side_d = lvl[k-1].side;
                    for (int j = 0; j < N; j++) begin
                        node_d[j] = LW'(lvl[k-1].node[2*j]) + LW'(lvl[k-1].node[2*j+1]);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) side_q <= '0;
                else       side_q <= side_d;
            end

            // NOTE: datapath registers carry no reset; the valid sideband alone qualifies them.
            always_ff @(posedge clk) begin
                node_q <= node_d;
            end

            assign node = node_q;
            assign side = side_q;
        end
    end

    logic signed [TW-1:0] tree_out;
    side_t                tside;
    assign tree_out = lvl[LOG2L].node[0];
    assign tside    = lvl[LOG2L].side;

    logic signed [AW-1:0] acc_d, acc_q, base, sum;
    logic signed [RW-1:0] res;
    logic                 first_beat_d, first_beat_q;
    logic [W-1:0]         res_w, c_d, c_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        acc_d        = acc_q;
        first_beat_d = first_beat_q;
        c_d          = c_q;
        out_valid_d  = out_valid_q;

        base = first_beat_q ? '0 : acc_q;
        sum  = base + AW'(tree_out);
        res  = RW'(sum) + RW'($signed(tside.bias));
        if (tside.relu && res < 0) res = '0;

        res_w = W'(res);
`ifdef ADDER_TREE_SATURATE_EN
        if (!res[RW-1] && |res[RW-2:W-1])      res_w = {1'b0, {(W-1){1'b1}}};
        else if (res[RW-1] && !(&res[RW-2:W-1])) res_w = {1'b1, {(W-1){1'b0}}};
`endif

        // Outside a stall the output stage is either empty or transferring, so it takes new data.
        if (!stall) begin
            out_valid_d = tside.valid && tside.last;
            if (tside.valid) begin
                if (tside.last) begin
                    c_d          = res_w;
                    acc_d        = '0;
                    first_beat_d = 1'b1;
                end else begin
                    acc_d        = sum;
                    first_beat_d = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            first_beat_q <= 1'b1;
            c_q          <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            first_beat_q <= first_beat_d;
            c_q          <= c_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench for pipelined_adder_tree at W=16, L=8.
// Inputs change just after the falling edge; outputs are sampled there too, away from the rising edge.
module tb_pipelined_adder_tree;
    localparam int W = 16;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_last, en_relu, out_valid, out_ready;
    logic [W*L-1:0] A_in;
    logic [W-1:0]   Bias, C;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] got [$];

    always #5 clk = ~clk;

    pipelined_adder_tree #(.W(W), .L(L), .ACC_GUARD(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .A_in(A_in), .Bias(Bias), .en_relu(en_relu),
        .out_valid(out_valid), .out_ready(out_ready), .C(C)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*L-1:0] fill(input logic [W-1:0] v);
        logic [W*L-1:0] r;
        for (int j = 0; j < L; j++) r[j*W +: W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] res_at(input int i);
        return (i < got.size()) ? got[i] : 'x;
    endfunction

    // Records a result that will transfer on the coming rising edge, then advances one cycle.
    task automatic tick();
        if (out_valid && out_ready) got.push_back(C);
        @(negedge clk);
    endtask

    task automatic beat(input logic [W*L-1:0] a, input logic last, input logic [W-1:0] b, input logic relu);
        in_valid = 1'b1; A_in = a; in_last = last; Bias = b; en_relu = relu;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && got.size() < n; i++) tick();
    endtask

    initial begin
        logic [W*L-1:0] seq;
        logic [W-1:0]   exp_pos, held_c;
        int             lat, idx, stalls_after;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; A_in = '0; Bias = '0;
        en_relu = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_C", 32'(C), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single beat 1..8 + bias 4 = 40, latency LOG2L+1 = 4.
        for (int j = 0; j < L; j++) seq[j*W +: W] = W'(j + 1);
        beat(seq, 1'b1, 16'd4, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_C", 32'(C), 32'd40);
        tick();
        check("t1_drop", 32'(out_valid), 32'd0);
        got.delete();

        // Three non-last all-ones beats with idle gaps, then last with bias -2: 4*8-2 = 30.
        for (int b = 0; b < 3; b++) begin
            beat(fill(16'd1), 1'b0, 16'h1234, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        check("t2_no_early_out", 32'(got.size()), 32'd0);
        beat(fill(16'd1), 1'b1, 16'hFFFE, 1'b0);
        drain(1, 20);
        for (int i = 0; i < 3; i++) tick();
        check("t2_count", 32'(got.size()), 32'd1);
        check("t2_C", 32'(res_at(0)), 32'd30);
        got.delete();

        // All -100: ReLU on gives 0, off gives -800.
        beat(fill(16'hFF9C), 1'b1, 16'd0, 1'b1);
        beat(fill(16'hFF9C), 1'b1, 16'd0, 1'b0);
        drain(2, 20);
        check("t3_relu_on", 32'(res_at(0)), 32'd0);
        check("t3_relu_off", 32'(res_at(1)), 32'h0000FCE0);
        got.delete();

        // Overflow: 8*0x7000 and 8*0x9000.
`ifdef ADDER_TREE_SATURATE_EN
        exp_pos = 16'h7FFF;
`else
        exp_pos = 16'h8000;
`endif
        beat(fill(16'h7000), 1'b1, 16'd0, 1'b0);
        beat(fill(16'h9000), 1'b1, 16'd0, 1'b0);
        drain(2, 20);
        check("t4_pos_ovf", 32'(res_at(0)), 32'(exp_pos));
        check("t4_neg_ovf", 32'(res_at(1)), 32'h00008000);
        got.delete();

        // Back-to-back neurons with out_ready low for cycles 6..10.
        idx = 0; stalls_after = 0; held_c = '0;
        for (int c = 0; c < 60 && got.size() < 12; c++) begin
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (idx < 12);
            A_in      = fill(W'(idx + 1));
            in_last   = 1'b1; Bias = '0; en_relu = 1'b0;
            #1;
            if (c == 8) begin
                check("t5_in_ready_stall", 32'(in_ready), 32'd0);
                check("t5_valid_stall", 32'(out_valid), 32'd1);
                held_c = C;
            end
            if (c == 10) check("t5_C_hold", 32'(C), 32'(held_c));
            if (c >= 11 && in_valid && !in_ready) stalls_after++;
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t5_count", 32'(got.size()), 32'd12);
        for (int k = 0; k < 12; k++) check($sformatf("t5_C%0d", k), 32'(res_at(k)), 32'(8 * (k + 1)));
        check("t5_resume_throughput", 32'(stalls_after), 32'd0);
        got.delete();

        // Reset after 2 of 4 beats have reached the accumulator; the next neuron must ignore them.
        beat(fill(16'd5), 1'b0, 16'd0, 1'b0);
        beat(fill(16'd5), 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_C", 32'(C), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t6_in_ready", 32'(in_ready), 32'd1);
        beat(fill(16'd3), 1'b1, 16'd1, 1'b0);
        drain(1, 20);
        for (int i = 0; i < 3; i++) tick();
        check("t6_count", 32'(got.size()), 32'd1);
        check("t6_C", 32'(res_at(0)), 32'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
